// File: rtl/roi_mask.sv
// roi_mask: region-of-interest pixel mask.
// Pixels whose (x,y) lies inside any of N_WIN rectangular windows, or outside
// all of them (cfg_mode = 1), pass through unchanged. All other pixels are
// replaced by a background colour.
// Configuration is written into a shadow bank. The shadow bank becomes active
// at the last pixel of a frame, or at an i_sof pixel.
// Latency is two cycles: stage 1 registers the classification flags and
// stage 2 selects the output colour.
// Optional feature macro: ROI_MASK_BORDER_EN. When it is defined, pixels on
// the perimeter of any enabled window are painted pure red.
module roi_mask #(
    parameter int P_W   = 11,
    parameter int C_W   = 8,
    parameter int IMG_X = 640,
    parameter int IMG_Y = 480,
    parameter int N_WIN = 2
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               i_valid,
    input  logic               i_sof,
    input  logic [C_W-1:0]     i_R,
    input  logic [C_W-1:0]     i_G,
    input  logic [C_W-1:0]     i_B,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_idx,
    input  logic [P_W-1:0]     cfg_x1,
    input  logic [P_W-1:0]     cfg_x2,
    input  logic [P_W-1:0]     cfg_y1,
    input  logic [P_W-1:0]     cfg_y2,
    input  logic               cfg_mode,
    input  logic [3*C_W-1:0]   cfg_bg,
    output logic               o_valid,
    output logic [C_W-1:0]     o_R,
    output logic [C_W-1:0]     o_G,
    output logic [C_W-1:0]     o_B,
    output logic               o_frame_done
);

    localparam int PIX_W = 3 * C_W;
    localparam logic [P_W-1:0] LAST_X = P_W'(IMG_X - 1);
    localparam logic [P_W-1:0] LAST_Y = P_W'(IMG_Y - 1);

    // Inclusive rectangle test. An inverted rectangle (x1>x2 or y1>y2) can never hit.
    function automatic logic in_window(input logic [P_W-1:0] x, input logic [P_W-1:0] y,
                                       input logic [P_W-1:0] x1, input logic [P_W-1:0] x2,
                                       input logic [P_W-1:0] y1, input logic [P_W-1:0] y2);
        return (x1 <= x) && (x <= x2) && (y1 <= y) && (y <= y2);
    endfunction

    // Output colour from the window hits: mode 0 passes inside any window,
    // mode 1 passes outside all windows.
    function automatic logic [PIX_W-1:0] select_pixel(input logic [N_WIN-1:0] hits,
                                                      input logic             mode,
                                                      input logic [PIX_W-1:0] pix,
                                                      input logic [PIX_W-1:0] bg);
        logic pass;
        pass = mode ? ~|hits : |hits;
        return pass ? pix : bg;
    endfunction

`ifdef ROI_MASK_BORDER_EN
    // Perimeter test. The caller qualifies the result with in_window.
    function automatic logic on_edge(input logic [P_W-1:0] x, input logic [P_W-1:0] y,
                                     input logic [P_W-1:0] x1, input logic [P_W-1:0] x2,
                                     input logic [P_W-1:0] y1, input logic [P_W-1:0] y2);
        return (x == x1) || (x == x2) || (y == y1) || (y == y2);
    endfunction

    // The border colour (full-scale red) overrides both pass and background.
    function automatic logic [PIX_W-1:0] apply_border(input logic on_border,
                                                      input logic [PIX_W-1:0] pix);
        return on_border ? {{C_W{1'b1}}, {(2*C_W){1'b0}}} : pix;
    endfunction
`endif

    // Position counters and the effective coordinate of the incoming pixel
    logic [P_W-1:0] cnt_x, cnt_y;
    logic [P_W-1:0] pos_x, pos_y;
    logic           last_pix;
    logic           commit;

    // Shadow (written by cfg) and active (used for classification) banks
    logic [P_W-1:0]   sh_x1 [N_WIN];
    logic [P_W-1:0]   sh_x2 [N_WIN];
    logic [P_W-1:0]   sh_y1 [N_WIN];
    logic [P_W-1:0]   sh_y2 [N_WIN];
    logic             sh_mode;
    logic [PIX_W-1:0] sh_bg;
    logic [P_W-1:0]   act_x1 [N_WIN];
    logic [P_W-1:0]   act_x2 [N_WIN];
    logic [P_W-1:0]   act_y1 [N_WIN];
    logic [P_W-1:0]   act_y2 [N_WIN];
    logic             act_mode;
    logic [PIX_W-1:0] act_bg;

    // Bank as seen by the incoming pixel
    logic             use_mode;
    logic [PIX_W-1:0] use_bg;
    logic [N_WIN-1:0] hit;

    // Stage 1 registers
    logic             vld_p1;
    logic             last_p1;
    logic [PIX_W-1:0] rgb_p1;
    logic [N_WIN-1:0] hit_p1;
    logic             mode_p1;
    logic [PIX_W-1:0] bg_p1;

`ifdef ROI_MASK_BORDER_EN
    logic [N_WIN-1:0] edge_hit;
    logic             edge_p1;
`endif

    // An i_sof pixel is (0,0) whatever the counters say.
    assign pos_x    = i_sof ? P_W'(0) : cnt_x;
    assign pos_y    = i_sof ? P_W'(0) : cnt_y;
    assign last_pix = (pos_x == LAST_X) && (pos_y == LAST_Y);
    assign commit   = i_valid && (i_sof || last_pix);

    // An i_sof pixel commits before it is classified, so it sees the shadow
    // bank directly. The frame's last pixel is still classified with the
    // outgoing active bank.
    assign use_mode = i_sof ? sh_mode : act_mode;
    assign use_bg   = i_sof ? sh_bg   : act_bg;

    for (genvar k = 0; k < N_WIN; k++) begin : g_win
        logic [P_W-1:0] x1, x2, y1, y2;
        assign x1     = i_sof ? sh_x1[k] : act_x1[k];
        assign x2     = i_sof ? sh_x2[k] : act_x2[k];
        assign y1     = i_sof ? sh_y1[k] : act_y1[k];
        assign y2     = i_sof ? sh_y2[k] : act_y2[k];
        assign hit[k] = in_window(pos_x, pos_y, x1, x2, y1, y2);
`ifdef ROI_MASK_BORDER_EN
        assign edge_hit[k] = hit[k] && on_edge(pos_x, pos_y, x1, x2, y1, y2);
`endif
    end

    // Advance the raster position on each accepted pixel, wrapping at line and frame ends
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_x <= '0;
            cnt_y <= '0;
        end else if (i_valid) begin
            if (pos_x == LAST_X) begin
                cnt_x <= '0;
                cnt_y <= (pos_y == LAST_Y) ? P_W'(0) : pos_y + P_W'(1);
            end else begin
                cnt_x <= pos_x + P_W'(1);
                cnt_y <= pos_y;
            end
        end
    end

    // Shadow bank: cfg writes land here. An index past the window count updates only mode and bg.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int k = 0; k < N_WIN; k++) begin
                sh_x1[k] <= (k == 0) ? P_W'(0) : P_W'(1);
                sh_x2[k] <= (k == 0) ? LAST_X  : P_W'(0);
                sh_y1[k] <= P_W'(0);
                sh_y2[k] <= (k == 0) ? LAST_Y  : P_W'(0);
            end
            sh_mode <= 1'b0;
            sh_bg   <= '0;
        end else if (cfg_we) begin
            for (int k = 0; k < N_WIN; k++) begin
                if (cfg_idx == 2'(k)) begin
                    sh_x1[k] <= cfg_x1;
                    sh_x2[k] <= cfg_x2;
                    sh_y1[k] <= cfg_y1;
                    sh_y2[k] <= cfg_y2;
                end
            end
            sh_mode <= cfg_mode;
            sh_bg   <= cfg_bg;
        end
    end

    // Active bank: takes the shadow contents present before any same-cycle cfg write
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int k = 0; k < N_WIN; k++) begin
                act_x1[k] <= (k == 0) ? P_W'(0) : P_W'(1);
                act_x2[k] <= (k == 0) ? LAST_X  : P_W'(0);
                act_y1[k] <= P_W'(0);
                act_y2[k] <= (k == 0) ? LAST_Y  : P_W'(0);
            end
            act_mode <= 1'b0;
            act_bg   <= '0;
        end else if (commit) begin
            for (int k = 0; k < N_WIN; k++) begin
                act_x1[k] <= sh_x1[k];
                act_x2[k] <= sh_x2[k];
                act_y1[k] <= sh_y1[k];
                act_y2[k] <= sh_y2[k];
            end
            act_mode <= sh_mode;
            act_bg   <= sh_bg;
        end
    end

    // ---- stage 1: register the pixel with its classification and the bank snapshot it used
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            rgb_p1  <= '0;
            hit_p1  <= '0;
            mode_p1 <= 1'b0;
            bg_p1   <= '0;
`ifdef ROI_MASK_BORDER_EN
            edge_p1 <= 1'b0;
`endif
        end else begin
            vld_p1  <= i_valid;
            last_p1 <= i_valid && last_pix;
            if (i_valid) begin
                rgb_p1  <= {i_R, i_G, i_B};
                hit_p1  <= hit;
                mode_p1 <= use_mode;
                bg_p1   <= use_bg;
`ifdef ROI_MASK_BORDER_EN
                edge_p1 <= |edge_hit;
`endif
            end
        end
    end

    // ---- stage 2: select the output colour. o_RGB keeps its last value while o_valid is low.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            o_valid      <= 1'b0;
            o_frame_done <= 1'b0;
            {o_R, o_G, o_B} <= '0;
        end else begin
            o_valid      <= vld_p1;
            o_frame_done <= vld_p1 && last_p1;
            if (vld_p1) begin
`ifdef ROI_MASK_BORDER_EN
                {o_R, o_G, o_B} <= apply_border(edge_p1,
                                                select_pixel(hit_p1, mode_p1, rgb_p1, bg_p1));
`else
                {o_R, o_G, o_B} <= select_pixel(hit_p1, mode_p1, rgb_p1, bg_p1);
`endif
            end
        end
    end

endmodule
